// File: rtl/stream_mux_rr.sv
// Registered N-channel valid/ready stream multiplexer with fixed or round-robin select.
// Optional transfer counter on out_cnt when MUX_CNT_EN is defined.
module stream_mux_rr #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] ctrl,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_ch
`ifdef MUX_CNT_EN
  ,
  output logic [15:0]     out_cnt
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    out_q;
  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] ptr_q;
  logic            found;
  logic [SELW-1:0] gnt_idx;
  logic            can_load;
  logic            xfer;

  assign can_load = (state_q == StEmpty) || out_ready;
  // in_ready is forced low while reset is held, hence rst_n in the transfer term.
  assign xfer     = rst_n && found && can_load;

  always_comb begin
    int unsigned idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!mode) begin
      if (32'(ctrl) < N) begin
        found   = in_valid[ctrl];
        gnt_idx = ctrl;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_q) + k) % N;
        if (!found && in_valid[idx[SELW-1:0]]) begin
          found   = 1'b1;
          gnt_idx = idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = StFull;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    out_valid = (state_q == StFull);
    out       = out_q;
    out_ch    = ch_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ch_q  <= '0;
      ptr_q <= '0;
    end else if (xfer) begin
      out_q <= in_data[gnt_idx*W +: W];
      ch_q  <= gnt_idx;
      // ptr only advances in round-robin mode; fixed mode leaves it untouched.
      if (mode) begin
        ptr_q <= (gnt_idx == SELW'(N - 1)) ? '0 : SELW'(gnt_idx + 1'b1);
      end
    end
  end

`ifdef MUX_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N=4 main instance, N=3 side instance).
// Counter checks run only when MUX_CNT_EN is defined.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  ctrl;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic        mode3;
  logic [1:0]  ctrl3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_ch3;

`ifdef MUX_CNT_EN
  logic [15:0] out_cnt;
  logic [15:0] out_cnt3;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.W(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .ctrl      (ctrl),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUX_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  stream_mux_rr #(.W(8), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .ctrl      (ctrl3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out       (out3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_ch    (out_ch3)
`ifdef MUX_CNT_EN
    ,
    .out_cnt   (out_cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = 1'b1;
    ctrl       = 2'd0;
    in_data    = 32'h44_33_22_11;
    in_valid   = 4'b1111;
    out_ready  = 1'b1;
    mode3      = 1'b0;
    ctrl3      = 2'd0;
    in_data3   = 24'hC3_B2_A1;
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;

    // Reset state, with requests present
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
`ifdef MUX_CNT_EN
    check("rst_cnt", 32'(out_cnt), 32'd0);
`endif
    in_valid = 4'b0000;
    #19 rst_n = 1'b1;
    tick();

    // 1: fixed select ctrl=1
    mode = 1'b0; ctrl = 2'd1; in_valid = 4'b0011;
    #1 check("t1_in_ready", 32'(in_ready), 32'b0010);
    tick();
    check("t1_out", 32'(out), 32'h22);
    check("t1_out_ch", 32'(out_ch), 32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    tick();
    check("t1_drain_valid", 32'(out_valid), 32'd0);
    check("t1_drain_out", 32'(out), 32'h22);

    // 2: round-robin, all valid; ptr starts at 0
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t2_ch%0d", k), 32'(out_ch), 32'(k % 4));
      check($sformatf("t2_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("t2_out%0d", k), 32'(out), 32'(8'h11 * ((k % 4) + 1)));
    end
    in_valid = 4'b0000;
    tick();

    // 3: ptr=2 now; channels 0 and 2 alternate
    in_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t3_ch%0d", k), 32'(out_ch), (k % 2 == 0) ? 32'd2 : 32'd0);
    end
    in_valid = 4'b0000;
    tick();

    // 4: backpressure holds A5
    mode = 1'b0; ctrl = 2'd1; in_data[15:8] = 8'hA5; in_valid = 4'b0010;
    tick();
    check("t4_load", 32'(out), 32'hA5);
    out_ready = 1'b0; in_data[15:8] = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_hold%0d", k), 32'(out), 32'hA5);
      check($sformatf("t4_hvalid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("t4_hready%0d", k), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1 check("t4_release_ready", 32'(in_ready), 32'b0010);
    tick();
    check("t4_next", 32'(out), 32'h5A);
    check("t4_next_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    tick();

    // 5: N=3, ctrl=3 out of range
    out_ready3 = 1'b0; ctrl3 = 2'd2; in_valid3 = 3'b111;
    tick();
    check("t5_load", 32'(out3), 32'hC3);
    ctrl3 = 2'd3; out_ready3 = 1'b1;
    #1 check("t5_in_ready", 32'(in_ready3), 32'h0);
    tick();
    check("t5_drained", 32'(out_valid3), 32'd0);
    check("t5_out_kept", 32'(out3), 32'hC3);
    tick();
    check("t5_in_ready2", 32'(in_ready3), 32'h0);
    check("t5_still_empty", 32'(out_valid3), 32'd0);
    in_valid3 = 3'b000;

    // 6: async reset mid-stream
    mode = 1'b1; in_valid = 4'b1111;
    tick();
    tick();
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out", 32'(out), 32'h0);
    check("t6_rst_ready", 32'(in_ready), 32'h0);
    #1 rst_n = 1'b1;
    #1 check("t6_first_ready", 32'(in_ready), 32'b0001);
    tick();
    check("t6_first_ch", 32'(out_ch), 32'd0);
    check("t6_first_out", 32'(out), 32'h11);

`ifdef MUX_CNT_EN
    // 7: counter, fresh reset
    in_valid = 4'b0000;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    check("t7_cnt5", 32'(out_cnt), 32'd5);
    for (int k = 0; k < 65530; k++) tick();
    check("t7_cnt_max", 32'(out_cnt), 32'hFFFF);
    tick();
    check("t7_cnt_wrap", 32'(out_cnt), 32'd0);
    in_valid = 4'b0000;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
